// File: rtl/sum_window_avg.sv
// sum_window_avg
// Accumulates windows of 2^N_LOG2 consecutive unsigned samples from the adder
// stream and presents each window's total, floor average and sequence index on
// a valid/ready output. s_ready depends combinationally on m_ready so that a
// result can be consumed and a new sample accepted on the same edge; the
// integrator must not close a loop from s_ready back into m_ready.
module sum_window_avg #(
   parameter int N_LOG2 = 2,
   parameter int IN_W   = 9,
   parameter int ACC_W  = IN_W + N_LOG2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ACC_W-1:0]  m_sum,
   output logic [IN_W-1:0]   m_avg,
   output logic [7:0]        m_index,
   output logic              m_valid,
   input  logic              m_ready
);

   // A one-sample window still gets a 1-bit counter; it simply never leaves 0.
   localparam int              CNT_W    = (N_LOG2 > 0) ? N_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << N_LOG2) - 1);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum_next;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       idx;
   logic             accept;
   logic             consume;
   logic             win_close;

   // Back-pressure: the block can take a sample whenever no result is stuck
   // waiting, including the cycle in which the pending result is consumed.
   assign s_ready   = !rst && (!m_valid || m_ready);
   assign accept    = s_valid && s_ready;
   assign consume   = m_valid && m_ready;
   assign win_close = accept && (cnt == CNT_LAST);

   // Running total including the sample on the input, zero-extended.
   assign sum_next  = acc + ACC_W'(s_data);

   // Window accumulation, result register and output handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         idx     <= '0;
         m_valid <= 1'b0;
         m_sum   <= '0;
         m_avg   <= '0;
         m_index <= '0;
      end else begin
         // NOTE: non-blocking assignments let the later window-close update
         // of m_valid override the consume clear on the same edge, and keep
         // every register reading the pre-edge values of its neighbours.
         if (consume) begin
            m_valid <= 1'b0;
         end
         if (accept) begin
            if (win_close) begin
               m_sum   <= sum_next;
               m_avg   <= IN_W'(sum_next >> N_LOG2);
               m_index <= idx;
               idx     <= idx + 8'd1;
               acc     <= '0;
               cnt     <= '0;
               m_valid <= 1'b1;
            end else begin
               acc <= sum_next;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/sum_window_avg.md
Name: sum_window_avg

Overview:
- Downstream consumer of the two-operand adder block's 9-bit unsigned sum stream.
- Accumulates fixed-size windows of 2^N_LOG2 consecutive sums.
- Emits the window total, the window average (floor) and an 8-bit window sequence index on a valid/ready output.
- Sits between the adder block and any logger/UART sink; supplies back-pressure to the adder through s_ready.

Parameters:
N_LOG2, 2, log2 of window length; window length W = 2^N_LOG2 samples; legal range 0..7.
IN_W, 9, input sample width; matches the adder sum width.
ACC_W, IN_W+N_LOG2, accumulator/total width; must not be overridden smaller.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  synchronous active-high reset.
s_data  input  IN_W  unsigned sample (adder o_data).
s_valid  input  1  sample valid.
s_ready  output  1  block can accept a sample.
m_sum  output  ACC_W  unsigned window total.
m_avg  output  IN_W  floor(m_sum / W), i.e. m_sum >> N_LOG2.
m_index  output  8  window sequence number; wraps 255->0.
m_valid  output  1  result valid.
m_ready  input  1  downstream accepts result.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Internal state: acc[ACC_W-1:0], cnt[N_LOG2-1:0] (absent/0 when N_LOG2=0), idx[7:0].
- Reset (rst high at a clk edge): acc=0, cnt=0, idx=0, m_valid=0, m_sum=0, m_avg=0, m_index=0.
- s_ready is forced 0 while rst is high.
- s_ready = !rst && (!m_valid || m_ready). This is a combinational path from m_ready; it is allowed and documented for the integrator.
- Input handshake: a sample is taken on an edge where s_valid && s_ready. s_data is ignored otherwise.
- Accepted sample with cnt != W-1: acc <= acc + s_data; cnt <= cnt+1.
- Accepted sample with cnt == W-1 (window close):
  - m_sum <= acc + s_data; m_avg <= (acc + s_data) >> N_LOG2.
  - m_index <= idx; idx <= idx+1 (mod 256).
  - acc <= 0; cnt <= 0; m_valid <= 1.
- Latency: m_valid rises on the edge that accepts the W-th sample, so the result is visible the cycle after that handshake.
- Output handshake: the result is consumed on an edge where m_valid && m_ready. m_valid <= 0 unless a new window closes on the same edge.
- Simultaneous output consume and window close: the new result loads and m_valid stays 1. This is only reachable when W=1 or through the s_ready bypass.
- While m_valid && !m_ready: m_sum, m_avg and m_index hold stable, s_ready=0, and acc/cnt are frozen.
- Back-to-back case: m_ready high while m_valid=1 lets a sample be accepted in the same cycle. That sample starts (or continues) the next window, so throughput is one sample per clock with no bubble.
- Width rule: acc never overflows, since W*(2^IN_W-1) fits in ACC_W bits. All arithmetic is unsigned and zero-extended.
- N_LOG2=0: every accepted sample closes a window; m_sum=m_avg=s_data.
- Reset mid-window: the partial window is discarded and idx restarts at 0. A pending unconsumed result is dropped (m_valid=0).
- No X propagation: outputs are registered and defined from reset.

Test Plan:
- rst high 3 cycles then low -> m_valid=0, m_sum=0, m_avg=0, m_index=0, s_ready=0 during rst and 1 on the first cycle after.
- N_LOG2=2, m_ready=1, samples 1,2,3,4 back-to-back -> m_valid high one cycle after the 4th handshake; m_sum=10, m_avg=2, m_index=0; one-cycle pulse.
- Four samples of 510 -> m_sum=2040, m_avg=510 (no overflow). Next window of 0,0,0,3 -> m_sum=3, m_avg=0, m_index=1.
- Back-pressure: result pending with m_ready=0 and s_valid=1, s_data=5 for 4 cycles -> s_ready=0 and outputs stable. Raise m_ready -> same edge consumes the result and accepts 5 as sample 1 of the next window.
- Reset mid-window: accept 100,100, pulse rst, then accept 4,4,4,4 -> m_sum=16, m_avg=4, m_index=0.
- Run 257 windows of four 1s with random m_ready stalls -> m_index sequence 0..255,0. Every m_sum=4, none dropped or duplicated (scoreboard count 257).
